// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder
// Instruction-memory responder for the fetch stage. A direct-mapped
// instruction cache answers one request per cycle with a one-cycle read
// latency. A miss stalls fetch and refills the line from backing memory.
//
// Ports
//   clk, rst_n       : clock (rising edge), asynchronous active-low reset
//   fetch_addr/valid : request from fetch; bits [1:0] of the address ignored
//   flush            : invalidate every line (fence.i)
//   instr_out        : instruction for the request accepted last cycle, or NOP
//   stall            : hold the fetch PC
//   mem_req_*        : line-aligned refill request (valid/ready handshake)
//   mem_resp_*       : refill beats, ascending word order
module imem_fetch_responder #(
    parameter int XLEN  = 32,
    parameter int LINES = 16,
    parameter int WPL   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] fetch_addr,
    input  logic            fetch_valid,
    input  logic            flush,
    output logic [XLEN-1:0] instr_out,
    output logic            stall,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_data
);
    localparam int OFF_W = $clog2(WPL);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = XLEN - IDX_W - OFF_W - 2;
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    typedef enum logic [1:0] {LOOKUP, MISS_REQ, REFILL} state_t;

    state_t              state_q, state_d;
    logic                pending_q, pending_d;
    logic [XLEN-3:0]     req_addr_q, req_addr_d;   // word address of the request
    logic [LINES-1:0]    valid_q, valid_d;
    logic [OFF_W-1:0]    cnt_q, cnt_d;
    logic                flush_pend_q, flush_pend_d;
    logic                mem_req_valid_q, mem_req_valid_d;
    logic [XLEN-1:0]     mem_req_addr_q, mem_req_addr_d;

    logic [XLEN-1:0]     data_arr [LINES*WPL];
    logic [TAG_W-1:0]    tag_arr  [LINES];
    logic [XLEN-1:0]     rd_data_q;
    logic [TAG_W-1:0]    rd_tag_q;

    logic [OFF_W-1:0]    f_off, r_off;
    logic [IDX_W-1:0]    f_idx, r_idx;
    logic [TAG_W-1:0]    r_tag;
    logic                accept, hit, beat, last_beat;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^fetch_addr[1:0];

    assign f_off = fetch_addr[2 +: OFF_W];
    assign f_idx = fetch_addr[OFF_W+2 +: IDX_W];
    assign r_off = req_addr_q[OFF_W-1:0];
    assign r_idx = req_addr_q[OFF_W +: IDX_W];
    assign r_tag = req_addr_q[XLEN-3 -: TAG_W];

    assign accept    = fetch_valid && !stall;
    // Hit uses the valid bits as they stand this cycle, so a flush
    // raised now only affects lookups from the next cycle on.
    assign hit       = pending_q && valid_q[r_idx] && (rd_tag_q == r_tag);
    assign beat      = (state_q == REFILL) && mem_resp_valid;
    assign last_beat = beat && (cnt_q == OFF_W'(WPL - 1));

    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = mem_req_addr_q;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOOKUP;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOOKUP:   if (pending_q && !hit) state_d = MISS_REQ;
            MISS_REQ: if (mem_req_ready)     state_d = REFILL;
            REFILL:   if (last_beat)         state_d = LOOKUP;
            default:                         state_d = LOOKUP;
        endcase
    end

    // FSM outputs toward fetch
    always_comb begin
        stall     = 1'b0;
        instr_out = NOP;
        case (state_q)
            LOOKUP: begin
                if (pending_q) begin
                    if (hit) instr_out = rd_data_q;
                    else     stall     = 1'b1;
                end
            end
            default: stall = 1'b1;
        endcase
    end

    // Control next state
    always_comb begin
        pending_d       = pending_q;
        req_addr_d      = req_addr_q;
        valid_d         = valid_q;
        cnt_d           = cnt_q;
        flush_pend_d    = flush_pend_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_req_addr_d  = mem_req_addr_q;

        if (accept) begin
            pending_d  = 1'b1;
            req_addr_d = fetch_addr[XLEN-1:2];
        end else if (!stall) begin
            pending_d  = 1'b0;
        end

        if (state_q == LOOKUP && state_d == MISS_REQ) begin
            mem_req_valid_d = 1'b1;
            mem_req_addr_d  = {req_addr_q[XLEN-3:OFF_W], {(OFF_W + 2){1'b0}}};
            flush_pend_d    = 1'b0;
        end

        if (state_q == MISS_REQ && mem_req_ready) begin
            mem_req_valid_d = 1'b0;
            cnt_d           = '0;
        end

        // Counter wraps to zero on the last beat (WPL is a power of two).
        if (beat) cnt_d = cnt_q + OFF_W'(1);

        // A flush seen while the miss is in flight leaves the refilled
        // line invalid so the re-lookup fetches it again.
        if (state_q != LOOKUP && flush) flush_pend_d = 1'b1;
        if (last_beat && !flush_pend_q && !flush) valid_d[r_idx] = 1'b1;
        if (flush) valid_d = '0;
    end

    // Control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q       <= 1'b0;
            req_addr_q      <= '0;
            valid_q         <= '0;
            cnt_q           <= '0;
            flush_pend_q    <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
        end else begin
            pending_q       <= pending_d;
            req_addr_q      <= req_addr_d;
            valid_q         <= valid_d;
            cnt_q           <= cnt_d;
            flush_pend_q    <= flush_pend_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
        end
    end

    // Storage arrays and read registers (not reset). The requested word and
    // tag are captured into the read registers during the refill so the
    // re-lookup sees the new line without another array read.
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_data_q <= data_arr[{f_idx, f_off}];
            rd_tag_q  <= tag_arr[f_idx];
        end
        if (beat) begin
            data_arr[{r_idx, cnt_q}] <= mem_resp_data;
            if (cnt_q == r_off) rd_data_q <= mem_resp_data;
        end
        if (last_beat) begin
            tag_arr[r_idx] <= r_tag;
            rd_tag_q       <= r_tag;
        end
    end
endmodule

// File: tb/tb_imem_fetch_responder.sv
// Testbench for imem_fetch_responder: directed scenarios followed by random
// fetch traffic, checked against a line-level cache model.
module tb_imem_fetch_responder;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int WPL = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] fetch_addr = '0;
    logic        fetch_valid = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] instr_out;
    logic        stall;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;

    int n_chk = 0;
    int n_fail = 0;

    // Model: which line holds which tag, and whether it is valid.
    bit   [15:0] mvalid = '0;
    logic [23:0] mtag [16];

    imem_fetch_responder #(.XLEN(32), .LINES(16), .WPL(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_addr(fetch_addr), .fetch_valid(fetch_valid), .flush(flush),
        .instr_out(instr_out), .stall(stall),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Backing memory contents: the test line 0x4000_0000 holds 0x11..0x44.
    function automatic logic [31:0] word(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        if (w[31:4] == 28'h400_0000) return (32'(w[3:2]) + 32'd1) * 32'h11;
        return (w * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Fetch inputs are don't-care while stalled; drive junk on them.
    task automatic garbage();
        fetch_valid = 1'($urandom);
        fetch_addr  = $urandom;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic serve_refill(input logic [31:0] line, input int rdy,
                                input int fl_beat, input int nbeats);
        int w;
        w = 0;
        while (!mem_req_valid && w < 4) begin
            garbage();
            tick();
            w++;
        end
        chk("req_valid", 32'(mem_req_valid), 32'd1);
        if (!mem_req_valid) return;
        chk("req_addr", mem_req_addr, line);
        for (int i = 0; i < rdy; i++) begin
            garbage();
            mem_resp_valid = 1'b1;          // stray beat outside REFILL
            mem_resp_data  = $urandom;
            tick();
            chk("req_hold_v", 32'(mem_req_valid), 32'd1);
            chk("req_hold_a", mem_req_addr, line);
        end
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b1;
        garbage();
        tick();
        mem_req_ready = 1'b0;
        chk("req_drop", 32'(mem_req_valid), 32'd0);
        for (int b = 0; b < nbeats; b++) begin
            repeat ($urandom_range(0, 1)) begin
                garbage();
                tick();
                chk("gap_stall", 32'(stall), 32'd1);
            end
            mem_resp_valid = 1'b1;
            mem_resp_data  = word(line + 32'(4 * b));
            flush          = (b == fl_beat);
            garbage();
            tick();
            mem_resp_valid = 1'b0;
            flush          = 1'b0;
            if (b < WPL - 1) chk("refill_stall", 32'(stall), 32'd1);
        end
        fetch_valid = 1'b0;
    endtask

    // Issue one request and follow it to delivery.
    task automatic fetch(input logic [31:0] a, input bit fl, input int rdy, input int fl_beat);
        logic [3:0]  idx;
        logic [23:0] tag;
        bit          hit;
        int          fb;
        fb = fl_beat;
        fetch_addr  = a;
        fetch_valid = 1'b1;
        flush       = fl;
        tick();
        fetch_valid = 1'b0;
        flush       = 1'b0;
        if (fl) mvalid = '0;
        idx = a[7:4];
        tag = a[31:8];
        hit = mvalid[idx] && (mtag[idx] == tag);
        while (!hit) begin
            chk("miss_stall", 32'(stall), 32'd1);
            chk("miss_nop", instr_out, NOP);
            serve_refill(a & 32'hFFFF_FFF0, rdy, fb, WPL);
            mtag[idx] = tag;
            if (fb >= 0) mvalid = '0;
            else mvalid[idx] = 1'b1;
            fb  = -1;
            hit = mvalid[idx] && (mtag[idx] == tag);
        end
        chk("hit_stall", 32'(stall), 32'd0);
        chk("hit_instr", instr_out, word(a));
        chk("hit_noreq", 32'(mem_req_valid), 32'd0);
    endtask

    task automatic idle(input int n, input bit fl);
        for (int i = 0; i < n; i++) begin
            fetch_valid = 1'b0;
            flush       = fl && (i == 0);
            tick();
            flush = 1'b0;
            if (fl && i == 0) mvalid = '0;
            chk("idle_stall", 32'(stall), 32'd0);
            chk("idle_nop", instr_out, NOP);
            chk("idle_noreq", 32'(mem_req_valid), 32'd0);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_reqv"}, 32'(mem_req_valid), 32'd0);
        chk({tag, "_reqa"}, mem_req_addr, 32'd0);
        chk({tag, "_instr"}, instr_out, NOP);
    endtask

    initial begin
        logic [31:0] a;
        logic [23:0] tg;

        // Reset asserted mid-cycle, before any clock edge.
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("rst");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Cold miss with two cycles of ready low, then sequential hits.
        fetch(32'h4000_0000, 1'b0, 2, -1);
        fetch(32'h4000_0004, 1'b0, 0, -1);
        fetch(32'h4000_0008, 1'b0, 0, -1);
        fetch(32'h4000_000C, 1'b0, 0, -1);

        // Conflict on index 0.
        fetch(32'h4000_0100, 1'b0, 0, -1);
        fetch(32'h4000_0000, 1'b0, 1, -1);

        // Standalone flush, then flush during a refill.
        fetch(32'h4000_0004, 1'b0, 0, -1);
        idle(1, 1'b1);
        fetch(32'h4000_0000, 1'b0, 0, -1);
        fetch(32'h4000_0100, 1'b0, 0, 1);

        // Reset after two refill beats.
        fetch_addr  = 32'h4000_0000;
        fetch_valid = 1'b1;
        tick();
        fetch_valid = 1'b0;
        chk("rmid_stall", 32'(stall), 32'd1);
        serve_refill(32'h4000_0000, 0, -1, 2);
        rst_n = 1'b0;
        #1 chk_reset_vals("rmid");
        repeat (2) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = $urandom;
            tick();
        end
        rst_n = 1'b1;
        repeat (2) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = $urandom;
            tick();
            chk_reset_vals("rpost");
        end
        mem_resp_valid = 1'b0;
        mvalid = '0;
        fetch(32'h4000_0000, 1'b0, 0, -1);

        // Random traffic over a few conflicting lines.
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 3))
                0:       tg = 24'h40_0000;
                1:       tg = 24'h40_0001;
                2:       tg = 24'hAB_CDEF;
                default: tg = 24'h00_0123;
            endcase
            a = {tg, 4'($urandom_range(0, 3)), 2'($urandom), 2'($urandom)};
            fetch(a, ($urandom % 16) == 0, $urandom_range(0, 2),
                  (($urandom % 8) == 0) ? int'($urandom_range(0, 3)) : -1);
            if (($urandom % 4) == 0) idle($urandom_range(1, 2), ($urandom % 5) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
